// File: rtl/bcd_counter2_if.sv
// Control and digit bus of the two-digit BCD counter.
// master: the side that drives enable/direction/load and watches the digits.
// slave:  the counter itself.
interface bcd_counter2_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_d;
  logic [3:0] load_u;
  logic [7:0] D;
  logic [7:0] U;
  logic       tc;

  modport master (
    output en, up, load, load_d, load_u,
    input  D, U, tc
  );

  modport slave (
    input  en, up, load, load_d, load_u,
    output D, U, tc
  );
endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD up/down counter (00-99) with a clock prescaler, synchronous
// clamped load, enable and a one-cycle terminal-count pulse.
// Optional macro BCD_COUNTER2_SATURATE_EN: stop at 99/00 instead of wrapping;
// tc then marks the first arrival at the limit.
module bcd_counter2 #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned DIV_W   = 26
) (
  input logic           clk,
  input logic           rst_n,
  bcd_counter2_if.slave bus
);

  localparam logic [DIV_W-1:0] PrescLast = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       d_q, d_d;
  logic [3:0]       u_q, u_d;
  logic             tc_q, tc_d;

  logic             tick;
  logic             at_max, at_min;
  logic [3:0]       inc_d, inc_u, dec_d, dec_u;

  // Digits above 9 load as 9 so no illegal code ever reaches the decoder.
  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign tick   = bus.en && !bus.load && (presc_q == PrescLast);
  assign at_max = (d_q == 4'd9) && (u_q == 4'd9);
  assign at_min = (d_q == 4'd0) && (u_q == 4'd0);

  // Wrapping increment/decrement of the two-digit value.
  always_comb begin
    inc_d = d_q;
    inc_u = u_q + 4'd1;
    if (u_q == 4'd9) begin
      inc_u = 4'd0;
      inc_d = (d_q == 4'd9) ? 4'd0 : d_q + 4'd1;
    end
    dec_d = d_q;
    dec_u = u_q - 4'd1;
    if (u_q == 4'd0) begin
      dec_u = 4'd9;
      dec_d = (d_q == 4'd0) ? 4'd9 : d_q - 4'd1;
    end
  end

  // Next state: load beats counting; tc only ever comes from a tick.
  always_comb begin
    presc_d = presc_q;
    d_d     = d_q;
    u_d     = u_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      presc_d = '0;
      d_d     = clamp9(bus.load_d);
      u_d     = clamp9(bus.load_u);
    end else if (bus.en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
`ifdef BCD_COUNTER2_SATURATE_EN
        if (bus.up) begin
          if (!at_max) begin
            d_d  = inc_d;
            u_d  = inc_u;
            tc_d = (inc_d == 4'd9) && (inc_u == 4'd9);
          end
        end else begin
          if (!at_min) begin
            d_d  = dec_d;
            u_d  = dec_u;
            tc_d = (dec_d == 4'd0) && (dec_u == 4'd0);
          end
        end
`else
        if (bus.up) begin
          d_d  = inc_d;
          u_d  = inc_u;
          tc_d = at_max;
        end else begin
          d_d  = dec_d;
          u_d  = dec_u;
          tc_d = at_min;
        end
`endif
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      d_q     <= 4'd0;
      u_q     <= 4'd0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      d_q     <= d_d;
      u_q     <= u_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.D  = {4'b0000, d_q};
  assign bus.U  = {4'b0000, u_q};
  assign bus.tc = tc_q;

endmodule

// File: tb/tb_bcd_counter2.sv
// Scoreboard bench for bcd_counter2: dut0 runs with CLK_DIV=4, dut1 with
// CLK_DIV=1. Stimulus pushes the expected post-edge state; per-DUT monitors
// pop and compare just after each rising edge.
module tb_bcd_counter2;

`ifdef BCD_COUNTER2_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic [7:0] u;
    logic       tc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  bcd_counter2_if bus0 ();
  bcd_counter2_if bus1 ();

  bcd_counter2 #(.CLK_DIV(4), .DIV_W(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  bcd_counter2 #(.CLK_DIV(1), .DIV_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic drive(input int k, input bit e, input bit u, input bit l,
                       input logic [3:0] ld, input logic [3:0] lu);
    if (k == 0) begin
      bus0.en = e; bus0.up = u; bus0.load = l; bus0.load_d = ld; bus0.load_u = lu;
    end else begin
      bus1.en = e; bus1.up = u; bus1.load = l; bus1.load_d = ld; bus1.load_u = lu;
    end
  endtask

  task automatic push(input int k, input int ed, input int eu, input bit etc,
                      input string name);
    exp_t x;
    x.d    = 8'(ed);
    x.u    = 8'(eu);
    x.tc   = etc;
    x.name = name;
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // One cycle of stimulus on one DUT plus its expected state after the edge.
  task automatic cyc(input int k, input bit e, input bit u, input bit l,
                     input logic [3:0] ld, input logic [3:0] lu,
                     input int ed, input int eu, input bit etc, input string name);
    @(negedge clk);
    drive(k, e, u, l, ld, lu);
    push(k, ed, eu, etc, name);
  endtask

  task automatic check(input int k, input exp_t x, input logic [7:0] d,
                       input logic [7:0] u, input logic tc);
    n_checks++;
    if (d !== x.d || u !== x.u || tc !== x.tc) begin
      n_errors++;
      $display("FAIL %s dut%0d @%0t: got D=%h U=%h tc=%b, expected D=%h U=%h tc=%b",
               x.name, k, $time, d, u, tc, x.d, x.u, x.tc);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        check(0, x, bus0.D, bus0.U, bus0.tc);
      end
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check(1, x, bus1.D, bus1.U, bus1.tc);
      end
    end
  end

  initial begin
    int v;
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);

    // Reset beats a concurrent load.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 1, 1, 1, 4'd5, 4'd5);
      drive(1, 1, 1, 1, 4'd5, 4'd5);
      push(0, 0, 0, 0, "reset");
      push(1, 0, 0, 0, "reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    push(0, 0, 0, 0, "idle");
    push(1, 0, 0, 0, "idle");

    // Up count, one step per 4 enabled cycles; 40 cycles -> 10.
    for (int i = 1; i <= 40; i++)
      cyc(0, 1, 1, 0, 0, 0, (i / 4) / 10, (i / 4) % 10, 0, "up_count");

    // Enable freeze: 2 enabled, 10 frozen, step after 2 more enabled.
    cyc(0, 1, 1, 0, 0, 0, 1, 0, 0, "pre_freeze");
    cyc(0, 1, 1, 0, 0, 0, 1, 0, 0, "pre_freeze");
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 1, 0, 0, 0, 1, 0, 0, "freeze");
    cyc(0, 1, 1, 0, 0, 0, 1, 0, 0, "resume");
    cyc(0, 1, 1, 0, 0, 0, 1, 1, 0, "resume_step");

    // Load with clamp during the tick cycle; prescaler restarts.
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 0, 0, 0, 1, 1, 0, "pre_load");
    cyc(0, 1, 1, 1, 4'd12, 4'd15, 9, 9, 0, "load_clamp");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 0, 0, 0, 9, 9, 0, "post_load_hold");
    cyc(0, 1, 1, 0, 0, 0, Sat ? 9 : 0, Sat ? 9 : 0, !Sat, "wrap_div4");
    cyc(0, 0, 1, 0, 0, 0, Sat ? 9 : 0, Sat ? 9 : 0, 0, "tc_drop_div4");

    // Up wrap at CLK_DIV=1.
    cyc(1, 1, 1, 1, 4'd9, 4'd8, 9, 8, 0, "load_98");
    cyc(1, 1, 1, 0, 0, 0, 9, 9, Sat, "up_99");
    cyc(1, 1, 1, 0, 0, 0, Sat ? 9 : 0, Sat ? 9 : 0, !Sat, "up_wrap");
    cyc(1, 1, 1, 0, 0, 0, Sat ? 9 : 0, Sat ? 9 : 1, 0, "up_after_wrap");

    // Down count with borrow and wrap.
    cyc(1, 1, 0, 1, 4'd1, 4'd0, 1, 0, 0, "load_10");
    for (int k = 1; k <= 10; k++) begin
      v = 10 - k;
      cyc(1, 1, 0, 0, 0, 0, v / 10, v % 10, Sat && (k == 10), "down");
    end
    cyc(1, 1, 0, 0, 0, 0, Sat ? 0 : 9, Sat ? 0 : 9, !Sat, "down_wrap");
    cyc(1, 1, 0, 0, 0, 0, Sat ? 0 : 9, Sat ? 0 : 8, 0, "down_after_wrap");

    // Loading the limits never raises tc.
    cyc(1, 0, 1, 1, 4'd9, 4'd9, 9, 9, 0, "load_99");
    cyc(1, 0, 1, 1, 4'd0, 4'd0, 0, 0, 0, "load_00");

    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0",
               q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
